// File: rtl/addr_share_seq_pkg.sv
// Shared types and constants for the nibble-serial shared-adder sequencer.
package addr_share_seq_pkg;

    localparam int NIB_W = 4;
    localparam int ID_W  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addr_share_seq_rca.sv
// Existing 4-bit ripple-carry adder datapath, purely combinational.
module ripple_carry_adder
    import addr_share_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    // NOTE: every always_comb output gets a value on every path (here the
    // loop covers all bits) so no latch is inferred.
    always_comb begin
        c   = '0;
        sum = '0;
        c[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/addr_share_seq.sv
// Two-requester round-robin front end that runs WIDTH-bit adds through one
// shared 4-bit adder, LSB nibble first, returning tagged results.
module addr_share_seq
    import addr_share_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = $clog2(NIB);

    state_t            state;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   grant_id;
    logic              armed;
    logic              accept;
    logic              carry;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  sum_sh;
    logic [NIB_W-1:0]  add_sum;
    logic              add_cout;

    ripple_carry_adder u_rca (
        .a    (a_sh[NIB_W-1:0]),
        .b    (b_sh[NIB_W-1:0]),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        grant_id = '0;
        if (req0_valid && req1_valid)
            grant_id = ~last_id;
        else if (req1_valid)
            grant_id = '1;
    end

    // armed keeps both readies low while reset is held and for the first
    // cycle after release, without feeding rst_n into the datapath.
    assign req0_ready = armed && (state == IDLE) && (grant_id == '0) && req0_valid;
    assign req1_ready = armed && (state == IDLE) && (grant_id != '0) && req1_valid;
    assign accept     = req0_ready || req1_ready;

    // The shift register and final carry are the response payload; they only
    // move in RUN, so they are stable for the whole DONE phase.
    assign rsp_sum  = sum_sh;
    assign rsp_cout = carry;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            last_id   <= '1;
            carry     <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= req1_ready ? req1_a   : req0_a;
                        b_sh    <= req1_ready ? req1_b   : req0_b;
                        carry   <= req1_ready ? req1_cin : req0_cin;
                        rsp_id  <= grant_id;
                        last_id <= grant_id;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= {add_sum, sum_sh[WIDTH-1:NIB_W]};
                    carry  <= add_cout;
                    a_sh   <= a_sh >> NIB_W;
                    b_sh   <= b_sh >> NIB_W;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NIB - 1)) begin
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_share_seq.sv
// Scoreboard bench for addr_share_seq: accepts push expected sums, responses
// pop and compare; directed cases cover arbitration, backpressure and reset.
module tb_addr_share_seq;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } op_t;

    typedef struct packed {
        logic           id;
        logic [WIDTH:0] res;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req0_cin;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_cin;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_cout, busy;
    logic [0:0]       rsp_id;
    logic [WIDTH-1:0] rsp_sum;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    logic grant_log[$];
    op_t  q0[$];
    op_t  q1[$];

    addr_share_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin);
        op_t o;
        o.a   = a;
        o.b   = b;
        o.cin = cin;
        return o;
    endfunction

    // Observes accepts and responses on the falling edge, away from the
    // active edge.
    task automatic monitor();
        logic             prev_v   = 1'b0;
        logic             hold     = 1'b0;
        logic             have_acc = 1'b0;
        logic             hold_id  = 1'b0;
        logic             hold_co  = 1'b0;
        logic [WIDTH-1:0] hold_sum = '0;
        int               acc_cyc  = 0;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                prev_v   = 1'b0;
                hold     = 1'b0;
                have_acc = 1'b0;
                continue;
            end
            if (req0_ready || req1_ready) begin
                check("one_ready", 32'(req0_ready && req1_ready), 0);
                check("ready_wo_valid",
                      32'((req0_ready && !req0_valid) || (req1_ready && !req1_valid)), 0);
                if (have_acc)
                    check("accept_spacing", 32'((cyc + 1 - acc_cyc) >= NIB + 2), 1);
                have_acc = 1'b1;
                acc_cyc  = cyc + 1;
                if (req0_ready) begin
                    e.id  = 1'b0;
                    e.res = {1'b0, req0_a} + {1'b0, req0_b} + {{WIDTH{1'b0}}, req0_cin};
                end else begin
                    e.id  = 1'b1;
                    e.res = {1'b0, req1_a} + {1'b0, req1_b} + {{WIDTH{1'b0}}, req1_cin};
                end
                sb.push_back(e);
                grant_log.push_back(e.id);
            end
            if (rsp_valid && !prev_v)
                check("latency", 32'(cyc - acc_cyc), NIB);
            if (hold) begin
                check("hold_valid", 32'(rsp_valid), 1);
                check("hold_sum",   32'(rsp_sum),   32'(hold_sum));
                check("hold_cout",  32'(rsp_cout),  32'(hold_co));
                check("hold_id",    32'(rsp_id),    32'(hold_id));
            end
            if (rsp_valid && rsp_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_id",       32'(rsp_id),              32'(e.id));
                    check("rsp_cout_sum", 32'({rsp_cout, rsp_sum}), 32'(e.res));
                end
            end
            hold     = rsp_valid && !rsp_ready;
            hold_sum = rsp_sum;
            hold_co  = rsp_cout;
            hold_id  = rsp_id[0];
            prev_v   = rsp_valid;
        end
    endtask

    // One cycle of requester activity; entered and left at posedge + 1.
    task automatic step_ops();
        logic a0, a1;
        req0_valid = (q0.size() != 0);
        if (q0.size() != 0) begin
            req0_a = q0[0].a; req0_b = q0[0].b; req0_cin = q0[0].cin;
        end
        req1_valid = (q1.size() != 0);
        if (q1.size() != 0) begin
            req1_a = q1[0].a; req1_b = q1[0].b; req1_cin = q1[0].cin;
        end
        @(negedge clk);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (a0) begin void'(q0.pop_front()); req0_valid = 1'b0; end
        if (a1) begin void'(q1.pop_front()); req1_valid = 1'b0; end
    endtask

    task automatic run_ops();
        int guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 200) begin
            step_ops();
            guard++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("run_ops_drained", 32'(q0.size() + q1.size()), 0);
    endtask

    task automatic wait_rsp();
        int guard = 0;
        while (!rsp_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rsp_seen", 32'(rsp_valid), 1);
    endtask

    task automatic drain();
        int guard = 0;
        while ((busy || sb.size() != 0) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_busy", 32'(busy), 0);
        check("drain_sb",   32'(sb.size()), 0);
    endtask

    initial begin
        int base;
        int guard;
        int vcount;

        fork
            monitor();
        join_none

        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid),  0);
        check("rst_busy",      32'(busy),       0);
        check("rst_ready0",    32'(req0_ready), 0);
        check("rst_ready1",    32'(req1_ready), 0);
        check("rst_rsp_sum",   32'(rsp_sum),    0);
        check("rst_rsp_cout",  32'(rsp_cout),   0);
        check("rst_rsp_id",    32'(rsp_id),     0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;

        // Both requesters continuously valid from reset: grants alternate 0,1,0,1.
        base = grant_log.size();
        q0.push_back(mk_op(16'h1111, 16'h2222, 1'b0));
        q0.push_back(mk_op(16'h7FFF, 16'h0001, 1'b1));
        q1.push_back(mk_op(16'hABCD, 16'h1234, 1'b1));
        q1.push_back(mk_op(16'hFFFF, 16'hFFFF, 1'b1));
        run_ops();
        drain();
        check("rr_count", 32'(grant_log.size() - base), 4);
        for (int i = 0; i < 4; i++)
            check("rr_order", 32'(grant_log[base + i]), 32'(i % 2));

        q0.push_back(mk_op(16'h1234, 16'h0FCD, 1'b1));
        run_ops();
        wait_rsp();
        check("d1_sum",  32'(rsp_sum),  32'h2202);
        check("d1_cout", 32'(rsp_cout), 0);
        check("d1_id",   32'(rsp_id),   0);
        drain();

        q1.push_back(mk_op(16'hFFFF, 16'h0001, 1'b0));
        run_ops();
        wait_rsp();
        check("d2_sum",  32'(rsp_sum),  32'h0000);
        check("d2_cout", 32'(rsp_cout), 1);
        check("d2_id",   32'(rsp_id),   1);
        drain();

        q0.push_back(mk_op(16'h0000, 16'h0000, 1'b1));
        run_ops();
        wait_rsp();
        check("d6_sum",  32'(rsp_sum),  32'h0001);
        check("d6_cout", 32'(rsp_cout), 0);
        drain();

        for (int i = 0; i < 5; i++) begin
            q0.push_back(mk_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom)));
            q1.push_back(mk_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom)));
        end
        run_ops();
        drain();

        // Backpressure in DONE with the other requester waiting.
        rsp_ready = 1'b0;
        base = grant_log.size();
        q0.push_back(mk_op(16'hAAAA, 16'h5555, 1'b1));
        q1.push_back(mk_op(16'h8000, 16'h8000, 1'b0));
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            step_ops();
            guard++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            step_ops();
            check("bp_valid_held", 32'(rsp_valid),  1);
            check("bp_busy",       32'(busy),       1);
            check("bp_ready0",     32'(req0_ready), 0);
            check("bp_ready1",     32'(req1_ready), 0);
        end
        rsp_ready = 1'b1;
        run_ops();
        drain();
        check("bp_grants",    32'(grant_log.size() - base), 2);
        check("bp_alternate", 32'(grant_log[base + 1]), 32'(!grant_log[base]));

        // Reset two cycles into RUN discards the operation and restores last_id.
        q0.push_back(mk_op(16'hFFFF, 16'hFFFF, 1'b1));
        run_ops();
        @(posedge clk);
        #3;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_n      = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid),  0);
        check("mid_rst_busy",      32'(busy),       0);
        check("mid_rst_sum",       32'(rsp_sum),    0);
        check("mid_rst_cout",      32'(rsp_cout),   0);
        check("mid_rst_id",        32'(rsp_id),     0);
        check("mid_rst_ready0",    32'(req0_ready), 0);
        check("mid_rst_ready1",    32'(req1_ready), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        @(posedge clk);
        #1;
        check("post_rst_no_rsp", 32'(vcount), 0);
        base = grant_log.size();
        q0.push_back(mk_op(16'h0F0F, 16'h00F1, 1'b0));
        q1.push_back(mk_op(16'h1000, 16'h2000, 1'b1));
        run_ops();
        drain();
        check("post_rst_first_grant", 32'(grant_log[base]), 0);
        check("post_rst_grants",      32'(grant_log.size() - base), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
